beta_mctl: RTL and testbench

BETA_MCTL -- requirements
Module: beta_mctl

---
 rtl/beta_mctl.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_beta_mctl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_mctl.sv
// Multicycle Beta control unit.
//
// Sequences each instruction through fetch, execute and, where needed, a memory
// wait or a fixed-latency MUL/DIV phase. Interrupts are taken only between
// instructions, from the fetch state, as a one-cycle trap through XADR.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   OP                opcode from the external IR (stable until return to fetch)
//   Z                 Ra==0 flag for BEQ/BNE
//   IRQ               level interrupt request
//   SUPER             supervisor mode; masks IRQ
//   MEM_RDY           memory access completes this cycle
//   ALUFN             ALU function code
//   ASEL, BSEL, RA2SEL, WASEL, MOE, MWR, WERF   datapath controls
//   PCSEL             0 PC+4, 1 branch, 2 JMP, 3 ILLOP, 4 XADR
//   WDSEL             0 PC+4, 1 ALU, 2 MEM
//   IR_LD             load IR from memory data
//   PC_LD             commit: load PC per PCSEL
//   MD_START          one-cycle start pulse to the MUL/DIV unit
module beta_mctl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 16,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned IRQ_EN     = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] OP,
    input  logic       Z,
    input  logic       IRQ,
    input  logic       SUPER,
    input  logic       MEM_RDY,
    output logic [5:0] ALUFN,
    output logic       ASEL,
    output logic       BSEL,
    output logic       RA2SEL,
    output logic       WASEL,
    output logic       MOE,
    output logic       MWR,
    output logic       WERF,
    output logic [2:0] PCSEL,
    output logic [1:0] WDSEL,
    output logic       IR_LD,
    output logic       PC_LD,
    output logic       MD_START
);

    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000001;
    localparam logic [5:0] ALU_MUL   = 6'b000010;
    localparam logic [5:0] ALU_DIV   = 6'b000011;
    localparam logic [5:0] ALU_AND   = 6'b011000;
    localparam logic [5:0] ALU_OR    = 6'b011110;
    localparam logic [5:0] ALU_XOR   = 6'b010110;
    localparam logic [5:0] ALU_XNOR  = 6'b011001;
    localparam logic [5:0] ALU_A     = 6'b011010;
    localparam logic [5:0] ALU_SHL   = 6'b100000;
    localparam logic [5:0] ALU_SHR   = 6'b100001;
    localparam logic [5:0] ALU_SRA   = 6'b100011;
    localparam logic [5:0] ALU_CMPEQ = 6'b110011;
    localparam logic [5:0] ALU_CMPLT = 6'b110101;
    localparam logic [5:0] ALU_CMPLE = 6'b110111;

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;
    localparam logic [5:0] OP_LDR = 6'h1F;

    localparam logic [2:0] PC_PC4   = 3'd0;
    localparam logic [2:0] PC_BR    = 3'd1;
    localparam logic [2:0] PC_JMP   = 3'd2;
    localparam logic [2:0] PC_ILLOP = 3'd3;
    localparam logic [2:0] PC_XADR  = 3'd4;

    localparam logic [1:0] WD_PC4 = 2'd0;
    localparam logic [1:0] WD_ALU = 2'd1;
    localparam logic [1:0] WD_MEM = 2'd2;

    // Counter preloads: S_MD lasts (load + 1) cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_MD, S_IRQ} state_t;
    typedef enum logic [2:0] {OcIll, OcOne, OcLoad, OcStore, OcMd} op_class_t;

    state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       irq_pend_q, irq_pend_d;
    logic       irq_set;

    logic [5:0] alu_fn;
    logic       alu_ok;
    logic [5:0] d_alufn;
    logic       d_asel, d_bsel, d_ra2sel, d_wasel;
    logic [1:0] d_wdsel;
    logic [2:0] d_pcsel;
    op_class_t  d_cls;
    logic       hold_mux;

    assign irq_set = (IRQ_EN != 0) && IRQ;

    // Single-cycle Beta decode of OP; defaults describe an illegal opcode.
    always_comb begin
        d_alufn  = ALU_ADD;
        d_asel   = 1'b0;
        d_bsel   = 1'b0;
        d_ra2sel = 1'b0;
        d_wdsel  = WD_PC4;
        d_pcsel  = PC_ILLOP;
        d_wasel  = 1'b1;
        d_cls    = OcIll;
        alu_fn   = ALU_ADD;
        alu_ok   = 1'b1;

        case (OP[3:0])
            4'h0:    alu_fn = ALU_ADD;
            4'h1:    alu_fn = ALU_SUB;
            4'h2:    alu_fn = ALU_MUL;
            4'h3:    alu_fn = ALU_DIV;
            4'h4:    alu_fn = ALU_CMPEQ;
            4'h5:    alu_fn = ALU_CMPLT;
            4'h6:    alu_fn = ALU_CMPLE;
            4'h8:    alu_fn = ALU_AND;
            4'h9:    alu_fn = ALU_OR;
            4'hA:    alu_fn = ALU_XOR;
            4'hB:    alu_fn = ALU_XNOR;
            4'hC:    alu_fn = ALU_SHL;
            4'hD:    alu_fn = ALU_SHR;
            4'hE:    alu_fn = ALU_SRA;
            default: alu_ok = 1'b0;
        endcase

        if (OP[5]) begin
            // 10xxxx register form, 11xxxx literal form
            if (alu_ok) begin
                d_alufn = alu_fn;
                d_bsel  = OP[4];
                d_wdsel = WD_ALU;
                d_pcsel = PC_PC4;
                d_wasel = 1'b0;
                d_cls   = (OP[3:1] == 3'b001) ? OcMd : OcOne;
            end
        end else begin
            case (OP)
                OP_LD: begin
                    d_bsel  = 1'b1;
                    d_wdsel = WD_MEM;
                    d_pcsel = PC_PC4;
                    d_wasel = 1'b0;
                    d_cls   = OcLoad;
                end
                OP_ST: begin
                    d_bsel   = 1'b1;
                    d_ra2sel = 1'b1;
                    d_pcsel  = PC_PC4;
                    d_wasel  = 1'b0;
                    d_cls    = OcStore;
                end
                OP_JMP: begin
                    d_pcsel = PC_JMP;
                    d_wasel = 1'b0;
                    d_cls   = OcOne;
                end
                OP_BEQ: begin
                    d_pcsel = Z ? PC_BR : PC_PC4;
                    d_wasel = 1'b0;
                    d_cls   = OcOne;
                end
                OP_BNE: begin
                    d_pcsel = Z ? PC_PC4 : PC_BR;
                    d_wasel = 1'b0;
                    d_cls   = OcOne;
                end
                OP_LDR: begin
                    d_asel  = 1'b1;
                    d_alufn = ALU_A;
                    d_wdsel = WD_MEM;
                    d_pcsel = PC_PC4;
                    d_wasel = 1'b0;
                    d_cls   = OcLoad;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_FETCH;
            cnt_q      <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign hold_mux = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_MD);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        irq_pend_d = irq_pend_q;
        ALUFN      = ALU_ADD;
        ASEL       = 1'b0;
        BSEL       = 1'b0;
        RA2SEL     = 1'b0;
        WASEL      = 1'b0;
        MOE        = 1'b0;
        MWR        = 1'b0;
        WERF       = 1'b0;
        PCSEL      = PC_PC4;
        WDSEL      = WD_PC4;
        IR_LD      = 1'b0;
        PC_LD      = 1'b0;
        MD_START   = 1'b0;

        // Clear in S_IRQ wins over a new request in the same cycle.
        if (state_q == S_IRQ) begin
            irq_pend_d = 1'b0;
        end else if (irq_set) begin
            irq_pend_d = 1'b1;
        end

        // Mux selects stay on the decoded values for the whole instruction.
        if (hold_mux) begin
            ALUFN  = d_alufn;
            ASEL   = d_asel;
            BSEL   = d_bsel;
            RA2SEL = d_ra2sel;
            WDSEL  = d_wdsel;
            WASEL  = d_wasel;
        end

        case (state_q)
            S_FETCH: begin
                if (irq_pend_q && !SUPER) begin
                    state_d = S_IRQ;
                end else begin
                    IR_LD = MEM_RDY;
                    if (MEM_RDY) begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                case (d_cls)
                    OcLoad, OcStore: state_d = S_MEM;
                    OcMd: begin
                        MD_START = 1'b1;
                        cnt_d    = (d_alufn == ALU_DIV) ? DIV_LOAD : MUL_LOAD;
                        state_d  = S_MD;
                    end
                    default: begin
                        PCSEL   = d_pcsel;
                        PC_LD   = 1'b1;
                        WERF    = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                MOE = (d_cls == OcLoad);
                MWR = (d_cls == OcStore);
                if (MEM_RDY) begin
                    PC_LD   = 1'b1;
                    WERF    = (d_cls == OcLoad);
                    state_d = S_FETCH;
                end
            end
            S_MD: begin
                if (cnt_q == '0) begin
                    PC_LD   = 1'b1;
                    WERF    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_IRQ: begin
                PCSEL   = PC_XADR;
                WASEL   = 1'b1;
                WDSEL   = WD_PC4;
                WERF    = 1'b1;
                PC_LD   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Strobes are gated by reset in the same cycle, so an access or
        // result in flight is dropped rather than committed.
        if (RESET) begin
            MWR      = 1'b0;
            WERF     = 1'b0;
            PC_LD    = 1'b0;
            IR_LD    = 1'b0;
            MD_START = 1'b0;
        end
    end

endmodule

// File: tb/tb_beta_mctl.sv
// Self-checking bench for beta_mctl: decode table plus multi-cycle sequences,
// with commits matched against a queue of expected commit records.
module tb_beta_mctl;

    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000001;
    localparam logic [5:0] ALU_MUL   = 6'b000010;
    localparam logic [5:0] ALU_DIV   = 6'b000011;
    localparam logic [5:0] ALU_XOR   = 6'b010110;
    localparam logic [5:0] ALU_A     = 6'b011010;
    localparam logic [5:0] ALU_SHL   = 6'b100000;
    localparam logic [5:0] ALU_CMPLT = 6'b110101;

    logic       CLK = 1'b0;
    logic       RESET, Z, IRQ, SUPER, MEM_RDY;
    logic [5:0] OP;
    logic [5:0] ALUFN;
    logic       ASEL, BSEL, RA2SEL, WASEL, MOE, MWR, WERF;
    logic [2:0] PCSEL;
    logic [1:0] WDSEL;
    logic       IR_LD, PC_LD, MD_START;

    always #5 CLK = ~CLK;

    beta_mctl #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(1),
        .CNT_W     (5),
        .IRQ_EN    (1)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .OP      (OP),
        .Z       (Z),
        .IRQ     (IRQ),
        .SUPER   (SUPER),
        .MEM_RDY (MEM_RDY),
        .ALUFN   (ALUFN),
        .ASEL    (ASEL),
        .BSEL    (BSEL),
        .RA2SEL  (RA2SEL),
        .WASEL   (WASEL),
        .MOE     (MOE),
        .MWR     (MWR),
        .WERF    (WERF),
        .PCSEL   (PCSEL),
        .WDSEL   (WDSEL),
        .IR_LD   (IR_LD),
        .PC_LD   (PC_LD),
        .MD_START(MD_START)
    );

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       z;
        logic [5:0] alufn;
        logic       asel;
        logic       bsel;
        logic       ra2sel;
        logic [1:0] wdsel;
        logic       md;
        logic [2:0] cpc;
        logic       cwerf;
        logic       wasel;
        int         lat;     // IR_LD cycle to commit cycle, MEM_RDY held high
    } vec_t;

    typedef struct {
        logic [2:0] pcsel;
        logic       werf;
        logic [1:0] wdsel;
        logic       wasel;
        int         lat;     // 0: no latency check (trap entry)
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   fetch_cyc = 0;
    int   md_pulses = 0;
    int   mwr_n, werf_n, pcld_n;

    task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        chk_w(nm, 32'(act), 32'(exp));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input string nm, input logic [5:0] op, input logic z,
                                input logic [5:0] fn, input logic a, input logic b,
                                input logic r, input logic [1:0] wd, input logic md,
                                input logic [2:0] cpc, input logic cw, input logic wa,
                                input int lat);
        vec_t v;
        v.name = nm; v.op = op; v.z = z; v.alufn = fn; v.asel = a; v.bsel = b;
        v.ra2sel = r; v.wdsel = wd; v.md = md; v.cpc = cpc; v.cwerf = cw;
        v.wasel = wa; v.lat = lat;
        return v;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Commit monitor: every PC_LD must match the oldest expected record.
    always @(negedge CLK) begin
        if (IR_LD === 1'b1) fetch_cyc = cyc;
        if (MD_START === 1'b1) md_pulses++;
        if (PC_LD === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_b("unexpected commit", PC_LD, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk_w("commit pcsel", 32'(PCSEL), 32'(mon_e.pcsel));
                chk_b("commit werf", WERF, mon_e.werf);
                chk_w("commit wdsel", 32'(WDSEL), 32'(mon_e.wdsel));
                chk_b("commit wasel", WASEL, mon_e.wasel);
                if (mon_e.lat > 0) chk_w("commit latency", cyc - fetch_cyc, mon_e.lat);
            end
        end
    end

    task automatic wait_commit(input string nm);
        int k = 0;
        while (PC_LD !== 1'b1 && k < 30) begin
            @(negedge CLK);
            k++;
        end
        chk_b({nm, " commit seen"}, PC_LD, 1'b1);
    endtask

    // Fetch with MEM_RDY=1, check the execute cycle, then run to commit.
    task automatic run_vec(input vec_t v);
        exp_t e;
        logic one;
        one = (v.lat == 1);
        e.pcsel = v.cpc; e.werf = v.cwerf; e.wdsel = v.wdsel; e.wasel = v.wasel;
        e.lat = v.lat;
        exp_q.push_back(e);
        OP = v.op; Z = v.z; MEM_RDY = 1'b1;
        @(negedge CLK);
        chk_b({v.name, " ir_ld"}, IR_LD, 1'b1);
        tick();
        @(negedge CLK);
        chk_w({v.name, " alufn"}, 32'(ALUFN), 32'(v.alufn));
        chk_b({v.name, " asel"}, ASEL, v.asel);
        chk_b({v.name, " bsel"}, BSEL, v.bsel);
        chk_b({v.name, " ra2sel"}, RA2SEL, v.ra2sel);
        chk_w({v.name, " wdsel"}, 32'(WDSEL), 32'(v.wdsel));
        chk_b({v.name, " wasel"}, WASEL, v.wasel);
        chk_b({v.name, " md_start"}, MD_START, v.md);
        chk_b({v.name, " mwr"}, MWR, 1'b0);
        chk_b({v.name, " exec pc_ld"}, PC_LD, one);
        chk_b({v.name, " exec werf"}, WERF, one ? v.cwerf : 1'b0);
        chk_w({v.name, " exec pcsel"}, 32'(PCSEL), one ? 32'(v.cpc) : 32'd0);
        wait_commit(v.name);
        tick();
        MEM_RDY = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        RESET = 1'b1; OP = 6'h00; Z = 1'b0; IRQ = 1'b0; SUPER = 1'b0; MEM_RDY = 1'b1;

        //         name      op     z     alufn      a     b     r     wd    md    cpc   cw    wa   lat
        vecs.push_back(mk("add",    6'h20, 1'b0, ALU_ADD,   1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("subc",   6'h31, 1'b0, ALU_SUB,   1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("cmplt",  6'h25, 1'b0, ALU_CMPLT, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("shlc",   6'h3C, 1'b0, ALU_SHL,   1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("xor",    6'h2A, 1'b0, ALU_XOR,   1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("ld",     6'h18, 1'b0, ALU_ADD,   1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3'd0, 1'b1, 1'b0, 2));
        vecs.push_back(mk("st",     6'h19, 1'b0, ALU_ADD,   1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 2));
        vecs.push_back(mk("ldr",    6'h1F, 1'b0, ALU_A,     1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 1'b1, 1'b0, 2));
        vecs.push_back(mk("jmp",    6'h1B, 1'b0, ALU_ADD,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1));
        vecs.push_back(mk("beq_z1", 6'h1C, 1'b1, ALU_ADD,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1));
        vecs.push_back(mk("beq_z0", 6'h1C, 1'b0, ALU_ADD,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("bne_z0", 6'h1D, 1'b0, ALU_ADD,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1));
        vecs.push_back(mk("bne_z1", 6'h1D, 1'b1, ALU_ADD,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("mul",    6'h22, 1'b0, ALU_MUL,   1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 3'd0, 1'b1, 1'b0, 5));
        vecs.push_back(mk("divc",   6'h33, 1'b0, ALU_DIV,   1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd0, 1'b1, 1'b0, 2));
        vecs.push_back(mk("ill00",  6'h00, 1'b0, ALU_ADD,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1));
        vecs.push_back(mk("ill27",  6'h27, 1'b0, ALU_ADD,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1));
        vecs.push_back(mk("ill3f",  6'h3F, 1'b0, ALU_ADD,   1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1));

        // Reset: strobes forced low even with MEM_RDY high in fetch.
        tick();
        tick();
        @(negedge CLK);
        chk_b("rst ir_ld", IR_LD, 1'b0);
        chk_b("rst pc_ld", PC_LD, 1'b0);
        chk_b("rst werf", WERF, 1'b0);
        chk_b("rst mwr", MWR, 1'b0);
        chk_b("rst md_start", MD_START, 1'b0);
        tick();
        RESET = 1'b0; MEM_RDY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk_w("post-reset idle outputs",
                  32'({ASEL, BSEL, RA2SEL, WASEL, MOE, MWR, WERF, IR_LD, PC_LD, MD_START,
                       PCSEL}), 32'd0);
            tick();
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // ST with MEM_RDY low for three memory cycles.
        e.pcsel = 3'd0; e.werf = 1'b0; e.wdsel = 2'd0; e.wasel = 1'b0; e.lat = 5;
        exp_q.push_back(e);
        OP = 6'h19; MEM_RDY = 1'b1;
        tick();
        MEM_RDY = 1'b0; mwr_n = 0; werf_n = 0;
        @(negedge CLK);
        chk_b("st exec mwr", MWR, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) MEM_RDY = 1'b1;
            @(negedge CLK);
            mwr_n += int'(MWR);
            werf_n += int'(WERF);
            chk_b("st pc_ld timing", PC_LD, k == 3);
        end
        tick();
        MEM_RDY = 1'b0;
        @(negedge CLK);
        mwr_n += int'(MWR);
        chk_w("st mwr cycles", mwr_n, 4);
        chk_w("st werf cycles", werf_n, 0);
        tick();

        // MUL with a one-cycle IRQ pulse in S_MD: MUL commits, then trap.
        md_pulses = 0;
        e.pcsel = 3'd0; e.werf = 1'b1; e.wdsel = 2'd1; e.wasel = 1'b0; e.lat = 5;
        exp_q.push_back(e);
        e.pcsel = 3'd4; e.werf = 1'b1; e.wdsel = 2'd0; e.wasel = 1'b1; e.lat = 0;
        exp_q.push_back(e);
        OP = 6'h22; MEM_RDY = 1'b1;
        tick();
        tick();
        IRQ = 1'b1;
        tick();
        IRQ = 1'b0;
        @(negedge CLK);
        wait_commit("mul irq");
        tick();
        @(negedge CLK);
        chk_b("irq pending no fetch", IR_LD, 1'b0);
        chk_b("irq pending no commit", PC_LD, 1'b0);
        tick();
        @(negedge CLK);
        chk_b("irq pc_ld", PC_LD, 1'b1);
        chk_w("irq pcsel", 32'(PCSEL), 32'd4);
        chk_b("irq wasel", WASEL, 1'b1);
        tick();
        chk_w("mul md_start pulses", md_pulses, 1);
        run_vec(vecs[0]);

        // IRQ held under SUPER=1 is never taken; it stays pending.
        SUPER = 1'b1; IRQ = 1'b1;
        run_vec(vecs[0]);
        run_vec(vecs[5]);
        IRQ = 1'b0;
        @(negedge CLK);
        chk_b("super idle no commit", PC_LD, 1'b0);
        tick();
        e.pcsel = 3'd4; e.werf = 1'b1; e.wdsel = 2'd0; e.wasel = 1'b1; e.lat = 0;
        exp_q.push_back(e);
        SUPER = 1'b0;
        @(negedge CLK);
        chk_b("unmask fetch no commit", PC_LD, 1'b0);
        tick();
        @(negedge CLK);
        chk_b("late irq pc_ld", PC_LD, 1'b1);
        chk_w("late irq pcsel", 32'(PCSEL), 32'd4);
        tick();

        // Reset in the second S_MEM cycle of an ST.
        OP = 6'h19; MEM_RDY = 1'b1;
        tick();
        MEM_RDY = 1'b0;
        tick();
        @(negedge CLK);
        chk_b("st mem1 mwr", MWR, 1'b1);
        tick();
        RESET = 1'b1;
        @(negedge CLK);
        chk_b("st rst mwr same cycle", MWR, 1'b0);
        chk_b("st rst pc_ld", PC_LD, 1'b0);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk_b("st after rst mwr", MWR, 1'b0);
        chk_b("st after rst moe", MOE, 1'b0);
        chk_b("st after rst pc_ld", PC_LD, 1'b0);
        tick();
        run_vec(vecs[0]);

        // Reset mid-MUL: the abandoned result is never committed.
        OP = 6'h22; MEM_RDY = 1'b1;
        tick();
        tick();
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0; MEM_RDY = 1'b0;
        pcld_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            pcld_n += int'(PC_LD);
            tick();
        end
        chk_w("abandoned mul commits", pcld_n, 0);
        run_vec(vecs[14]);

        chk_w("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
